// File: rtl/gamepad_scanner.sv
// Serial gamepad sequencer: one latch pulse, BUTTON_COUNT clock pulses, both pads sampled LSB first.
// Define GAMEPAD_SYNC_EN to pass the pad data pins through 2-flop synchronizers (needs CLK_DIV >= 3).
module gamepad_scanner #(
  parameter int CLK_DIV      = 4,
  parameter int BUTTON_COUNT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    gamepad_latch,
  output logic                    gamepad_clk,
  input  logic                    p1_data,
  input  logic                    p2_data,
  output logic [BUTTON_COUNT-1:0] p1_buttons,
  output logic [BUTTON_COUNT-1:0] p2_buttons,
  output logic                    valid
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_DONE
  } state_t;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [5:0] LAST_IDX = 6'(BUTTON_COUNT - 1);

  state_t                  state_reg, state_next;
  logic [7:0]              div_reg, div_next;
  logic [5:0]              idx_reg, idx_next;
  logic                    latch_reg, latch_next;
  logic                    gclk_reg, gclk_next;
  logic                    busy_reg, busy_next;
  logic                    valid_reg, valid_next;
  logic                    capture;
  logic [BUTTON_COUNT-1:0] cap_mask;
  logic [BUTTON_COUNT-1:0] p1_shift_reg, p2_shift_reg;
  logic [BUTTON_COUNT-1:0] p1_buttons_reg, p2_buttons_reg;
  logic                    p1_sample, p2_sample;

`ifdef GAMEPAD_SYNC_EN
  logic [1:0] p1_sync_reg, p2_sync_reg;

  // Pins idle high (no button pressed), so the synchronizers reset to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_sync_reg <= 2'b11;
      p2_sync_reg <= 2'b11;
    end else begin
      p1_sync_reg <= {p1_sync_reg[0], p1_data};
      p2_sync_reg <= {p2_sync_reg[0], p2_data};
    end
  end

  assign p1_sample = p1_sync_reg[1];
  assign p2_sample = p2_sync_reg[1];

  if (CLK_DIV < 3) begin : g_bad_clk_div
    $fatal(1, "gamepad_scanner: CLK_DIV must be >= 3 with GAMEPAD_SYNC_EN");
  end
`else
  assign p1_sample = p1_data;
  assign p2_sample = p2_data;
`endif

  // The LATCH state reuses the bit index as a half counter, so the 8-bit
  // divider only ever counts one CLK_DIV period.
  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    idx_next   = idx_reg;
    latch_next = 1'b0;
    gclk_next  = 1'b1;
    valid_next = 1'b0;
    capture    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_LATCH;
          div_next   = DIV_LOAD;
          idx_next   = 6'd0;
          latch_next = 1'b1;
        end
      end

      ST_LATCH: begin
        latch_next = 1'b1;
        if (div_reg != 8'd0) begin
          div_next = div_reg - 8'd1;
        end else if (idx_reg == 6'd0) begin
          idx_next = 6'd1;
          div_next = DIV_LOAD;
        end else begin
          state_next = ST_CLK_LO;
          idx_next   = 6'd0;
          div_next   = DIV_LOAD;
          latch_next = 1'b0;
          gclk_next  = 1'b0;
          capture    = 1'b1;
        end
      end

      ST_CLK_LO: begin
        gclk_next = 1'b0;
        if (div_reg != 8'd0) begin
          div_next = div_reg - 8'd1;
        end else begin
          state_next = ST_CLK_HI;
          div_next   = DIV_LOAD;
          gclk_next  = 1'b1;
        end
      end

      ST_CLK_HI: begin
        if (div_reg != 8'd0) begin
          div_next = div_reg - 8'd1;
        end else if (idx_reg == LAST_IDX) begin
          state_next = ST_DONE;
          idx_next   = idx_reg + 6'd1;
          div_next   = 8'd0;
          valid_next = 1'b1;
        end else begin
          state_next = ST_CLK_LO;
          idx_next   = idx_reg + 6'd1;
          div_next   = DIV_LOAD;
          gclk_next  = 1'b0;
          capture    = 1'b1;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
        div_next   = 8'd0;
        idx_next   = 6'd0;
      end

      default: begin
        state_next = ST_IDLE;
        div_next   = 8'd0;
        idx_next   = 6'd0;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  // One-hot write enable: the bit being captured is the index we are entering CLK_LO with.
  for (genvar gi = 0; gi < BUTTON_COUNT; gi++) begin : g_cap_mask
    assign cap_mask[gi] = capture && (idx_next == 6'(gi));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      div_reg   <= 8'd0;
      idx_reg   <= 6'd0;
      latch_reg <= 1'b0;
      gclk_reg  <= 1'b1;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      idx_reg   <= idx_next;
      latch_reg <= latch_next;
      gclk_reg  <= gclk_next;
      busy_reg  <= busy_next;
      valid_reg <= valid_next;
    end
  end

  // Pad data is active-low; stored words use 1 = pressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_shift_reg <= '0;
      p2_shift_reg <= '0;
    end else begin
      p1_shift_reg <= (p1_shift_reg & ~cap_mask) | ({BUTTON_COUNT{~p1_sample}} & cap_mask);
      p2_shift_reg <= (p2_shift_reg & ~cap_mask) | ({BUTTON_COUNT{~p2_sample}} & cap_mask);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_buttons_reg <= '0;
      p2_buttons_reg <= '0;
    end else if (valid_next) begin
      p1_buttons_reg <= p1_shift_reg;
      p2_buttons_reg <= p2_shift_reg;
    end
  end

  assign busy          = busy_reg;
  assign gamepad_latch = latch_reg;
  assign gamepad_clk   = gclk_reg;
  assign valid         = valid_reg;
  assign p1_buttons    = p1_buttons_reg;
  assign p2_buttons    = p2_buttons_reg;

endmodule

// File: tb/tb_gamepad_scanner.sv
// Bench for gamepad_scanner: pad shift-register model, cycle-offset timing model, directed scans.
module tb_gamepad_scanner;
  localparam int D  = 4;
  localparam int BC = 16;
  localparam int T  = (2 + 2 * BC) * D;  // cycles from E0 to the valid cycle

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        p1_data, p2_data;
  logic        busy, gamepad_latch, gamepad_clk, valid;
  logic [15:0] p1_buttons, p2_buttons;

  logic [15:0] p1_word = 16'h0000;
  logic [15:0] p2_word = 16'h0000;
  int          pad_pos = 0;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          k = -1;           // cycles since E0 of the current scan, -1 when idle
  logic [15:0] exp1 = 16'h0000;
  logic [15:0] exp2 = 16'h0000;

  int          lat_cnt = 0;
  int          lo_cnt = 0;
  int          fall_cnt = 0;
  int          valid_cnt = 0;
  int          valid_times[$];
  logic        prev_gclk = 1'b1;

  always #5 clk = ~clk;

  gamepad_scanner #(.CLK_DIV(D), .BUTTON_COUNT(BC)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .gamepad_latch(gamepad_latch),
    .gamepad_clk  (gamepad_clk),
    .p1_data      (p1_data),
    .p2_data      (p2_data),
    .p1_buttons   (p1_buttons),
    .p2_buttons   (p2_buttons),
    .valid        (valid)
  );

  // Pad: latch reloads, each rising clock advances to the next bit; pressed = low.
  always @(posedge gamepad_clk or posedge gamepad_latch) begin
    if (gamepad_latch) pad_pos <= 0;
    else               pad_pos <= pad_pos + 1;
  end
  assign p1_data = (pad_pos < 16) ? ~p1_word[pad_pos[3:0]] : 1'b0;
  assign p2_data = (pad_pos < 16) ? ~p2_word[pad_pos[3:0]] : 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Timing model: a scan is just an offset k from the accepting edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      k    <= -1;
      exp1 <= 16'h0000;
      exp2 <= 16'h0000;
    end else if (k < 0 || k > T) begin
      k <= start ? 0 : -1;
    end else begin
      k <= k + 1;
      if (k + 1 == T) begin
        exp1 <= p1_word;
        exp2 <= p2_word;
      end
    end
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    logic exp_gclk;
    @(negedge clk);
    exp_gclk = !(k >= 2 * D && k < T && ((k - 2 * D) % (2 * D)) < D);
    chk("latch", 32'(gamepad_latch), 32'(k >= 0 && k < 2 * D));
    chk("gclk", 32'(gamepad_clk), 32'(exp_gclk));
    chk("busy", 32'(busy), 32'(k >= 0 && k <= T));
    chk("valid", 32'(valid), 32'(k == T));
    chk("p1_buttons", 32'(p1_buttons), 32'(exp1));
    chk("p2_buttons", 32'(p2_buttons), 32'(exp2));
    if (gamepad_latch) lat_cnt++;
    if (!gamepad_clk) lo_cnt++;
    if (prev_gclk && !gamepad_clk) fall_cnt++;
    prev_gclk = gamepad_clk;
    if (valid) begin
      valid_cnt++;
      valid_times.push_back(cyc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_scan(input logic [15:0] w1, input logic [15:0] w2);
    int b_lat, b_lo, b_fall, b_val, vq, e0;
    p1_word = w1;
    p2_word = w2;
    b_lat = lat_cnt; b_lo = lo_cnt; b_fall = fall_cnt; b_val = valid_cnt;
    vq = valid_times.size();
    start = 1'b1;
    step();
    e0 = cyc;
    start = 1'b0;
    repeat (T + 3) step();
    chk("latch_cycles", lat_cnt - b_lat, 8);
    chk("clk_low_pulses", fall_cnt - b_fall, 16);
    chk("clk_low_cycles", lo_cnt - b_lo, 64);
    chk("valid_count", valid_cnt - b_val, 1);
    chk("valid_latency", (valid_times.size() > vq) ? valid_times[vq] - e0 : 0, 136);
    chk("p1_word", 32'(p1_buttons), 32'(w1));
    chk("p2_word", 32'(p2_buttons), 32'(w2));
  endtask

  initial begin
    int b_lat, b_val, vq, e0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) step();
    chk("rst_gclk", 32'(gamepad_clk), 1);
    chk("rst_latch", 32'(gamepad_latch), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_p1", 32'(p1_buttons), 0);
    chk("rst_p2", 32'(p2_buttons), 0);

    run_scan(16'h0001, 16'h0000);
    run_scan(16'hA5C3, 16'h8000);

    // Starts mid-scan and in the DONE cycle must be dropped.
    b_lat = lat_cnt; b_val = valid_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (19) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (116) step();
    chk("done_valid", 32'(valid), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    chk("ign_valid_count", valid_cnt - b_val, 1);
    chk("ign_latch_cycles", lat_cnt - b_lat, 8);
    chk("ign_busy", 32'(busy), 0);

    // Held start: back-to-back scans every 138 cycles.
    vq = valid_times.size();
    start = 1'b1;
    step();
    e0 = cyc;
    repeat (400) step();
    chk("held_busy", 32'(busy), 1);
    chk("held_valids", valid_times.size() - vq, 2);
    if (valid_times.size() >= vq + 2) begin
      chk("held_v1", valid_times[vq] - e0, 136);
      chk("held_v2", valid_times[vq + 1] - e0, 274);
    end
    start = 1'b0;
    repeat (T + 5) step();

    // Asynchronous reset in the middle of a bit.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (50) step();
    chk("pre_rst_gclk", 32'(gamepad_clk), 0);
    chk("pre_rst_p1", 32'(p1_buttons), 32'h0000A5C3);
    reset = 1'b1;
    #1;
    chk("arst_gclk", 32'(gamepad_clk), 1);
    chk("arst_latch", 32'(gamepad_latch), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_p1", 32'(p1_buttons), 0);
    chk("arst_p2", 32'(p2_buttons), 0);
    #1;
    reset = 1'b0;
    repeat (3) step();
    run_scan(16'h5A3C, 16'h0F0F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gamepad_scanner.md
# gamepad_scanner

Hardware sequencer for the two serial (SNES-style) gamepad ports, replacing software bit-banging of gamepad latch/clock through the pad register window. On a start request it drives one latch pulse and a fixed train of clock pulses. It samples both pads' data lines and publishes both button words atomically with a one-cycle valid strobe. It sits between the Wishbone adapter (pad window reads the button words) and the gamepad IO pins; `start` is typically tied to the VDP `frame_ended` strobe.

## Interface
- `CLK_DIV`, default 4: cycles per half clock period; the latch is 2*CLK_DIV cycles; legal range 2..255 (3..255 with sync enabled).
- `BUTTON_COUNT`, default 16: bits shifted per scan; legal range 1..32.

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `start` in 1: scan request; honoured only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `gamepad_latch` out 1: latch pin drive.
- `gamepad_clk` out 1: clock pin drive, idle high.
- `p1_data` in 1: pad 1 serial data, active-low.
- `p2_data` in 1: pad 2 serial data, active-low.
- `p1_buttons` out BUTTON_COUNT: last completed pad 1 word, 1 = pressed.
- `p2_buttons` out BUTTON_COUNT: last completed pad 2 word, 1 = pressed.
- `valid` out 1: one-cycle strobe; button words updated on this edge.

## Operation
- States: IDLE, LATCH, CLK_LO, CLK_HI, DONE. All outputs registered.
- Reset values: state IDLE, `gamepad_latch`=0, `gamepad_clk`=1, `busy`=0, `valid`=0, both button words 0, shift registers 0, counters 0.
- IDLE → LATCH on the edge sampling `start`=1. In LATCH, `gamepad_latch`=1 for 2*CLK_DIV cycles, then → CLK_LO with bit index 0.
- On the LATCH→CLK_LO and CLK_HI→CLK_LO edges, the current sampled data is captured: bit[i] = ~data. `gamepad_clk` goes 0 on the same edge. The data is stable since latch fall or the previous rising edge.
- CLK_LO lasts CLK_DIV cycles (`gamepad_clk`=0), then → CLK_HI.
- CLK_HI lasts CLK_DIV cycles (`gamepad_clk`=1). After it, the index increments and the next state is CLK_LO. When the index reaches BUTTON_COUNT, the next state is DONE instead.
- Bit 0 is the first bit after latch fall; it lands in `pN_buttons[0]`.
- DONE lasts one cycle: `valid`=1, both words copied from the shift registers on entering, then → IDLE.
- A `start` during any non-IDLE state is ignored, not queued. A `start` in the DONE cycle is also ignored.
- A `start` held high continuously re-triggers on the first IDLE cycle after DONE.
- Counters: divider is 8 bits and reloads at each state entry; index is 6 bits. No wrap beyond BUTTON_COUNT.
- Reset mid-scan: outputs return to reset values asynchronously. Partial data is discarded and the button words are cleared to 0.

## Timing
- Edge E0 accepts `start`. `busy` and `gamepad_latch` go high after E0.
- Latch falls at E0 + 2*CLK_DIV.
- Total scan: 2*CLK_DIV + BUTTON_COUNT*2*CLK_DIV cycles. `valid` is high for the one cycle after edge E0 + (2+2*BUTTON_COUNT)*CLK_DIV.
- `busy` falls one cycle after `valid`.
- Default parameters: `valid` asserts 136 cycles after E0; minimum restart interval is 138 cycles.
- Button words hold their value between `valid` strobes. There is no combinational path from any input to any output.

## Configuration
- `GAMEPAD_SYNC_EN` defined: `p1_data`/`p2_data` each pass through a 2-flop synchronizer before capture. The captured bit reflects the pin 2 cycles before the capture edge. CLK_DIV must be ≥3; a simulation-only check stops if it is not.
- Not defined: data pins are captured directly with no synchronizer. This is for benches and for pads already registered externally.

## Test plan
- Reset, then 10 idle cycles → `gamepad_clk`=1, `gamepad_latch`=0, `busy`=0, `valid`=0, buttons 16'h0000.
- CLK_DIV=4. Pulse `start`; pad model drives `p1_data` for word 16'h0001 (bit 0 low) and `p2_data` all high. Expect:
  - latch high for exactly 8 cycles;
  - 16 clock low pulses, each 4 cycles;
  - `valid` 136 cycles after E0;
  - `p1_buttons`=16'h0001, `p2_buttons`=16'h0000.
- Pads return 16'hA5C3 pressed on P1 and 16'h8000 pressed on P2 → words match exactly, confirming LSB-first order.
- `start` pulses at E0+20 and on the DONE cycle → ignored: exactly one `valid`, and no latch pulse until a fresh `start` in IDLE.
- `start` held high for 400 cycles → `valid` at 136 and 274, and a third scan in progress at cycle 400.
- Async `reset` at E0+50, mid-bit → `gamepad_clk`=1, `gamepad_latch`=0, buttons 0 before the next edge. A new scan after release completes normally.
